// File: rtl/gate_response_checker.sv
// Purpose : checks {a,b,c} samples of a 2-input gate against TRUTH, counts vectors/mismatches, tracks coverage, gives a verdict.
// Latency : every effect of an accepted sample (counters, cov, capture, state, verdict) is visible one cycle after it.
// Backpress: none; samples are taken whenever smp_valid=1 in RUN and dropped otherwise. Option macro: GATE_CHK_HALT_EN (halt on first mismatch).
module gate_response_checker #(
  parameter logic [3:0] TRUTH = 4'b0110,
  parameter int         NVEC  = 4,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             smp_a,
  input  logic             smp_b,
  input  logic             smp_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             ff_vld,
  output logic [2:0]       ff_vec
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] NVEC_C  = CNT_W'(NVEC);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic             accept;
  logic             exp_c;
  logic             mis;
  logic             err_sat;
  logic             last;
  logic             halt;
  logic             finish;
  logic             clear;
  logic [CNT_W-1:0] vec_nxt;
  logic [CNT_W-1:0] err_fin;
  logic [3:0]       cov_hit;
  logic [3:0]       cov_fin;

  // Sample evaluation: expected output, mismatch, and the post-sample counter/coverage values.
  always_comb begin
    idx     = {smp_a, smp_b};
    accept  = (state == S_RUN) && smp_valid;
    exp_c   = TRUTH[idx];
    mis     = accept && (smp_c != exp_c);
    err_sat = (err_cnt == CNT_MAX);
    vec_nxt = vec_cnt + ONE;
    err_fin = (mis && !err_sat) ? (err_cnt + ONE) : err_cnt;
    cov_hit = 4'b0001 << idx;
    cov_fin = accept ? (cov | cov_hit) : cov;
    last    = accept && (vec_nxt == NVEC_C);
`ifdef GATE_CHK_HALT_EN
    halt    = mis;
`else
    halt    = 1'b0;
`endif
    finish  = accept && (last || halt);
    // A start seen outside RUN opens a fresh run; any sample in that same cycle is dropped.
    clear   = start && ((state == S_IDLE) || (state == S_DONE));
  end

  // Next-state logic; any unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)  state_nxt = S_RUN;
      S_RUN:   if (finish) state_nxt = S_DONE;
      S_DONE:  if (start)  state_nxt = S_RUN;
      default:             state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs: status flags follow the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      vec_cnt <= '0;
      err_cnt <= '0;
      cov     <= 4'b0000;
      ff_vld  <= 1'b0;
      ff_vec  <= 3'b000;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      if (clear) begin
        pass    <= 1'b0;
        vec_cnt <= '0;
        err_cnt <= '0;
        cov     <= 4'b0000;
        ff_vld  <= 1'b0;
        ff_vec  <= 3'b000;
      end else if (accept) begin
        vec_cnt <= vec_nxt;
        err_cnt <= err_fin;
        cov     <= cov_fin;
        if (mis && !ff_vld) begin
          ff_vld <= 1'b1;
          ff_vec <= {smp_a, smp_b, smp_c};
        end
        // Verdict includes the contribution of the sample that ends the run.
        if (finish) pass <= (err_fin == '0) && (cov_fin == 4'b1111);
      end
    end
  end

endmodule
